// File: rtl/mips_store_monitor.sv
// Store-bus self-check monitor: compares every core store against a programmed
// table of expected (address, data) pairs and reports pass / fail / timeout.
module mips_store_monitor #(
   parameter int               WIDTH      = 32,
   parameter int               N_EXP      = 4,
   parameter int               ORDERED    = 1,
   parameter int               IGNORE_EN  = 1,
   parameter logic [WIDTH-1:0] IGNORE_ADR = WIDTH'(80),
   parameter int               TIMEOUT    = 64,
   localparam int              IW         = (N_EXP > 1) ? $clog2(N_EXP) : 1,
   localparam int              CW         = $clog2(N_EXP + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cfg_we,
   input  logic [IW-1:0]    cfg_idx,
   input  logic [WIDTH-1:0] cfg_adr,
   input  logic [WIDTH-1:0] cfg_data,
   input  logic             memwrite,
   input  logic [WIDTH-1:0] dataadr,
   input  logic [WIDTH-1:0] writedata,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [CW-1:0]    match_cnt,
   output logic [WIDTH-1:0] fail_adr,
   output logic [WIDTH-1:0] fail_data
);

   localparam int            TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;
   state_t state, state_n;

   logic [WIDTH-1:0] tab_adr  [N_EXP];
   logic [WIDTH-1:0] tab_data [N_EXP];
   logic [CW-1:0]    exp_cnt, exp_cnt_n, match_cnt_n;
   logic [N_EXP-1:0] matched, matched_n, eq;
   logic [TW-1:0]    cyc, cyc_n;
   logic             pass_n, fail_n, timeout_n;
   logic [WIDTH-1:0] fail_adr_n, fail_data_n;
   logic             tab_we, idx_ok, ignored, hit;

   // Indices past the table depth (non power-of-two N_EXP) are dropped.
   assign idx_ok  = ({1'b0, cfg_idx} < (IW+1)'(N_EXP));
   assign ignored = (IGNORE_EN != 0) && (dataadr == IGNORE_ADR);
   assign busy    = (state == S_RUN);

   always_comb begin
      for (int i = 0; i < N_EXP; i++)
         eq[i] = (tab_adr[i] == dataadr) && (tab_data[i] == writedata);
   end

   always_comb begin
      state_n     = state;
      exp_cnt_n   = exp_cnt;
      match_cnt_n = match_cnt;
      matched_n   = matched;
      cyc_n       = cyc;
      pass_n      = pass;
      fail_n      = fail;
      timeout_n   = timeout;
      fail_adr_n  = fail_adr;
      fail_data_n = fail_data;
      tab_we      = 1'b0;
      hit         = 1'b0;
      case (state)
         S_RUN: begin
            if (cyc != TO_LIM)
               cyc_n = cyc + 1'b1;
            if (memwrite && !ignored) begin
               for (int i = 0; i < N_EXP; i++) begin
                  if (ORDERED != 0) begin
                     if (CW'(i) == match_cnt && eq[i]) begin
                        hit          = 1'b1;
                        matched_n[i] = 1'b1;
                     end
                  end else if (!hit && CW'(i) < exp_cnt && !matched[i] && eq[i]) begin
                     hit          = 1'b1;
                     matched_n[i] = 1'b1;
                  end
               end
               if (hit) begin
                  match_cnt_n = match_cnt + 1'b1;
                  if (match_cnt_n == exp_cnt) begin
                     state_n = S_PASS;
                     pass_n  = 1'b1;
                  end
               end else begin
                  state_n     = S_FAIL;
                  fail_n      = 1'b1;
                  timeout_n   = 1'b0;
                  fail_adr_n  = dataadr;
                  fail_data_n = writedata;
               end
            end
            // A store that decides the check on the timeout cycle takes priority.
            if (TIMEOUT != 0 && state_n == S_RUN && cyc_n == TO_LIM) begin
               state_n     = S_FAIL;
               fail_n      = 1'b1;
               timeout_n   = 1'b1;
               fail_adr_n  = '0;
               fail_data_n = '0;
            end
         end
         default: begin
            if (state == S_IDLE && cfg_we && idx_ok) begin
               tab_we = 1'b1;
               if (CW'(cfg_idx) >= exp_cnt)
                  exp_cnt_n = CW'(cfg_idx) + 1'b1;
            end
            if (start) begin
               match_cnt_n = '0;
               matched_n   = '0;
               cyc_n       = '0;
               fail_n      = 1'b0;
               timeout_n   = 1'b0;
               fail_adr_n  = '0;
               fail_data_n = '0;
               if (exp_cnt_n == '0) begin
                  state_n = S_PASS;
                  pass_n  = 1'b1;
               end else begin
                  state_n = S_RUN;
                  pass_n  = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         exp_cnt   <= '0;
         match_cnt <= '0;
         matched   <= '0;
         cyc       <= '0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         timeout   <= 1'b0;
         fail_adr  <= '0;
         fail_data <= '0;
         for (int i = 0; i < N_EXP; i++) begin
            tab_adr[i]  <= '0;
            tab_data[i] <= '0;
         end
      end else begin
         state     <= state_n;
         exp_cnt   <= exp_cnt_n;
         match_cnt <= match_cnt_n;
         matched   <= matched_n;
         cyc       <= cyc_n;
         pass      <= pass_n;
         fail      <= fail_n;
         timeout   <= timeout_n;
         fail_adr  <= fail_adr_n;
         fail_data <= fail_data_n;
         if (tab_we) begin
            for (int i = 0; i < N_EXP; i++) begin
               if (IW'(i) == cfg_idx) begin
                  tab_adr[i]  <= cfg_adr;
                  tab_data[i] <= cfg_data;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mips_store_monitor.sv
// Bench for mips_store_monitor: an ordered (TIMEOUT=64) and an unordered
// (TIMEOUT=10) instance share stimulus and are checked against a queue model.
module tb_mips_store_monitor;

   localparam int PH_IDLE = 0, PH_RUN = 1, PH_PASS = 2, PH_FAIL = 3;
   localparam int TMO_O = 64, TMO_U = 10;

   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, cfg_we = 1'b0, memwrite = 1'b0;
   logic [1:0]  cfg_idx = '0;
   logic [31:0] cfg_adr = '0, cfg_data = '0, dataadr = '0, writedata = '0;
   logic        o_busy, o_pass, o_fail, o_timeout, u_busy, u_pass, u_fail, u_timeout;
   logic [2:0]  o_match, u_match;
   logic [31:0] o_fadr, o_fdata, u_fadr, u_fdata;

   int n_total = 0, n_bad = 0;
   bit checking = 1'b0;

   mips_store_monitor #(.WIDTH(32), .N_EXP(4), .ORDERED(1), .IGNORE_EN(1),
                        .IGNORE_ADR(32'd80), .TIMEOUT(TMO_O)) dut_o (
      .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_adr(cfg_adr), .cfg_data(cfg_data), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .busy(o_busy), .pass(o_pass), .fail(o_fail),
      .timeout(o_timeout), .match_cnt(o_match), .fail_adr(o_fadr), .fail_data(o_fdata));

   mips_store_monitor #(.WIDTH(32), .N_EXP(4), .ORDERED(0), .IGNORE_EN(1),
                        .IGNORE_ADR(32'd80), .TIMEOUT(TMO_U)) dut_u (
      .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_adr(cfg_adr), .cfg_data(cfg_data), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .busy(u_busy), .pass(u_pass), .fail(u_fail),
      .timeout(u_timeout), .match_cnt(u_match), .fail_adr(u_fadr), .fail_data(u_fdata));

   always #5 clk = ~clk;

   // ---------------- behavioural model: remaining expected stores as queues
   int          m_ph[2], m_exp[2], m_match[2], m_cyc[2];
   bit          m_pass[2], m_fail[2], m_to[2];
   logic [31:0] m_fadr[2], m_fdata[2];
   logic [63:0] m_tab[2][4];
   logic [63:0] rem_o[$], rem_u[$];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ph[k] = PH_IDLE; m_exp[k] = 0; m_match[k] = 0; m_cyc[k] = 0;
         m_pass[k] = 0; m_fail[k] = 0; m_to[k] = 0; m_fadr[k] = 0; m_fdata[k] = 0;
         for (int i = 0; i < 4; i++) m_tab[k][i] = '0;
      end
      rem_o.delete();
      rem_u.delete();
   endtask

   task automatic model_step(input int k);
      logic [63:0] q[$];
      logic [63:0] st;
      int hit, tmo;
      bit decided;
      tmo = (k == 0) ? TMO_O : TMO_U;
      if (k == 0) q = rem_o; else q = rem_u;
      if (m_ph[k] == PH_IDLE && cfg_we) begin
         m_tab[k][cfg_idx] = {cfg_adr, cfg_data};
         if (int'(cfg_idx) + 1 > m_exp[k]) m_exp[k] = int'(cfg_idx) + 1;
      end
      if (start && m_ph[k] != PH_RUN) begin
         q.delete();
         for (int i = 0; i < m_exp[k]; i++) q.push_back(m_tab[k][i]);
         m_match[k] = 0; m_cyc[k] = 0; m_fail[k] = 0; m_to[k] = 0;
         m_fadr[k] = 0; m_fdata[k] = 0;
         m_pass[k] = (q.size() == 0);
         m_ph[k]   = (q.size() == 0) ? PH_PASS : PH_RUN;
      end else if (m_ph[k] == PH_RUN) begin
         decided = 0;
         m_cyc[k]++;
         if (memwrite && dataadr != 32'd80) begin
            st  = {dataadr, writedata};
            hit = -1;
            if (k == 0) begin
               if (q[0] == st) hit = 0;
            end else begin
               for (int i = 0; i < q.size(); i++)
                  if (hit < 0 && q[i] == st) hit = i;
            end
            if (hit >= 0) begin
               q.delete(hit);
               m_match[k]++;
               if (q.size() == 0) begin
                  m_ph[k] = PH_PASS; m_pass[k] = 1; decided = 1;
               end
            end else begin
               m_ph[k] = PH_FAIL; m_fail[k] = 1; decided = 1;
               m_fadr[k] = dataadr; m_fdata[k] = writedata;
            end
         end
         if (!decided && m_cyc[k] >= tmo) begin
            m_ph[k] = PH_FAIL; m_fail[k] = 1; m_to[k] = 1;
         end
      end
      if (k == 0) rem_o = q; else rem_u = q;
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) model_reset();
      else begin
         model_step(0);
         model_step(1);
      end
   end

   // ---------------- scoreboard
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_all();
      chk("o_busy",  o_busy,    m_ph[0] == PH_RUN);
      chk("o_pass",  o_pass,    m_pass[0]);
      chk("o_fail",  o_fail,    m_fail[0]);
      chk("o_tmo",   o_timeout, m_to[0]);
      chk("o_match", o_match,   m_match[0]);
      chk("o_fadr",  o_fadr,    m_fadr[0]);
      chk("o_fdata", o_fdata,   m_fdata[0]);
      chk("u_busy",  u_busy,    m_ph[1] == PH_RUN);
      chk("u_pass",  u_pass,    m_pass[1]);
      chk("u_fail",  u_fail,    m_fail[1]);
      chk("u_tmo",   u_timeout, m_to[1]);
      chk("u_match", u_match,   m_match[1]);
      chk("u_fadr",  u_fadr,    m_fadr[1]);
      chk("u_fdata", u_fdata,   m_fdata[1]);
   endtask

   always @(negedge clk) if (checking) check_all();

   // ---------------- drivers
   logic [31:0] sa[4], sd[4];

   task automatic drive(input bit s, input bit we, input int idx, input logic [31:0] ca,
                        input logic [31:0] cd, input bit mw, input logic [31:0] a,
                        input logic [31:0] d);
      @(negedge clk);
      start = s; cfg_we = we; cfg_idx = 2'(idx); cfg_adr = ca; cfg_data = cd;
      memwrite = mw; dataadr = a; writedata = d;
   endtask

   task automatic idle();             drive(0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic go();               drive(1, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      drive(0, 0, 0, 0, 0, 1, a, d);
   endtask
   task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] d);
      drive(0, 1, idx, a, d, 0, 0, 0);
      sa[idx] = a; sd[idx] = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin sa[i] = 0; sd[i] = 0; end
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [31:0] pick_adr();
      case ($urandom_range(0, 4))
         0: return 32'd60;
         1: return 32'd64;
         2: return 32'd80;
         3: return 32'd84;
         default: return 32'd88;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, r;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checking = 1'b1;
      idle();
      chk("rst_pass", {o_pass, u_pass, o_fail, u_fail, o_busy, u_busy}, 0);
      chk("rst_match", {o_match, u_match}, 0);

      // T1: ignored scratch store, then the single expected store
      cfg(0, 84, 7); go(); store(80, 3); idle();
      chk("t1_ign_pass", o_pass, 0);
      chk("t1_ign_match", o_match, 0);
      store(84, 7); idle();
      chk("t1_pass", o_pass, 1);
      chk("t1_match", o_match, 1);

      // T2 (ordered) / T3 (unordered): out-of-order stores
      do_reset();
      cfg(0, 60, 1); cfg(1, 64, 2); go(); store(64, 2); idle();
      chk("t2_fail", {o_fail, o_timeout}, 2'b10);
      chk("t2_fadr", o_fadr, 64);
      chk("t2_fdata", o_fdata, 2);
      chk("t2_match", o_match, 0);
      chk("t3_u_mid", {u_busy, u_match}, {1'b1, 3'd1});
      store(60, 1); idle();
      chk("t3_u_pass", {u_pass, u_fail}, 2'b10);
      chk("t3_u_match", u_match, 2);
      go(); store(64, 2); idle();
      chk("t3_dup1", {u_fail, u_match}, {1'b0, 3'd1});
      store(64, 2); idle();
      chk("t3_dup2", {u_fail, u_timeout}, 2'b10);
      chk("t3_dup_adr", u_fadr, 64);

      // T4: timeout after exactly 10 RUN cycles (unordered instance)
      do_reset();
      cfg(0, 84, 7); go();
      repeat (10) idle();
      chk("t4_before", {u_busy, u_fail}, 2'b10);
      idle();
      chk("t4_tmo", {u_busy, u_fail, u_timeout}, 3'b011);
      chk("t4_fadr", u_fadr, 0);

      // completing / mismatching store on the timeout cycle
      go(); repeat (9) idle(); store(84, 7); idle();
      chk("tc_pass", {u_pass, u_fail, u_timeout}, 3'b100);
      go(); repeat (9) idle(); store(84, 9); idle();
      chk("tc_miss", {u_pass, u_fail, u_timeout}, 3'b010);
      chk("tc_miss_data", u_fdata, 9);

      // T5: asynchronous reset mid-RUN, then empty table passes at once
      go(); idle(); idle();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("t5_async", {o_busy, u_busy, o_pass, u_pass, o_fail, u_fail, o_match, u_match}, 0);
      @(negedge clk);
      reset = 1'b0;
      go(); idle();
      chk("t5_empty_pass", {o_pass, u_pass, o_busy, u_busy}, 4'b1100);

      // T6: cfg writes during RUN are ignored; restart from PASS clears flags
      do_reset();
      cfg(0, 84, 7); go(); cfg(2, 90, 9); store(84, 7); idle();
      chk("t6_pass", {o_pass, o_match}, {1'b1, 3'd1});
      go(); idle();
      chk("t6_restart", {o_pass, o_fail, o_busy}, 3'b001);

      // randomized episodes
      for (int ep = 0; ep < 60; ep++) begin
         if ($urandom_range(0, 3) == 0) do_reset();
         n = $urandom_range(0, 4);
         for (int j = 0; j < n; j++)
            cfg($urandom_range(0, 3), pick_adr(), $urandom_range(0, 3));
         go();
         for (int c = 0; c < 25; c++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
               n = $urandom_range(0, 3);
               store(sa[n], sd[n]);
            end else if (r == 5) store(pick_adr(), $urandom_range(0, 3));
            else if (r == 6) go();
            else if (r == 7) cfg($urandom_range(0, 3), pick_adr(), $urandom_range(0, 3));
            else idle();
         end
         idle();
      end
      idle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
